// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the IFU/LSU requesters, the arbiter and the data memory.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) arbiter and sequencer for a single handshaked data memory.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority, LSU over IFU.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              wen_q,   wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic grant_ifu, grant_lsu;
  logic ifu_ready, lsu_ready;
  logic ifu_resp,  lsu_resp;

`ifdef ARB_RR_EN
  owner_e last_grant_q, last_grant_d;

  // On contention the requester that was not served last wins.
  always_comb begin
    grant_lsu = bus.lsu_req_valid &&
                (!bus.ifu_req_valid || (last_grant_q == OWN_IFU));
    grant_ifu = bus.ifu_req_valid && !grant_lsu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= OWN_IFU;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant_lsu = bus.lsu_req_valid;
    grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    ifu_ready = 1'b0;
    lsu_ready = 1'b0;
    ifu_resp  = 1'b0;
    lsu_resp  = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted so no handshake is seen.
        ifu_ready = grant_ifu && !rst;
        lsu_ready = grant_lsu && !rst;
        if (grant_lsu) begin
          state_d = REQ;
          owner_d = OWN_LSU;
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
`ifdef ARB_RR_EN
          last_grant_d = OWN_LSU;
`endif
        end else if (grant_ifu) begin
          state_d = REQ;
          owner_d = OWN_IFU;
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
`ifdef ARB_RR_EN
          last_grant_d = OWN_IFU;
`endif
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_LSU) lsu_resp = 1'b1;
          else                    ifu_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = ifu_resp;
  assign bus.lsu_resp_valid = lsu_resp;
  assign bus.ifu_rdata      = ifu_resp ? bus.mem_rdata : '0;
  assign bus.lsu_rdata      = lsu_resp ? bus.mem_rdata : '0;

  assign bus.mem_req_valid  = (state_q == REQ);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; expectations follow ARB_RR_EN when defined.
module tb_mem_arbiter;
  typedef struct packed {
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [31:0] ld;
    logic [3:0]  lm;
    logic        mrr;
    logic        mrv;
    logic [31:0] mrd;
  } in_t;

  typedef struct packed {
    logic        ir;
    logic        lr;
    logic        irv;
    logic [31:0] ird;
    logic        lrv;
    logic [31:0] lrd;
    logic        mv;
    logic [31:0] ma;
    logic        mw;
    logic [31:0] md;
    logic [3:0]  mm;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t tbl[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic in_t ii(logic iv, logic [31:0] ia, logic lv, logic [31:0] la, logic lw,
                             logic [31:0] ld, logic [3:0] lm, logic mrr, logic mrv,
                             logic [31:0] mrd);
    in_t r;
    r.iv = iv; r.ia = ia; r.lv = lv; r.la = la; r.lw = lw;
    r.ld = ld; r.lm = lm; r.mrr = mrr; r.mrv = mrv; r.mrd = mrd;
    return r;
  endfunction

  // Read data is required to be zero whenever the matching resp_valid is low.
  function automatic out_t oo(logic ir, logic lr, logic irv, logic lrv, logic [31:0] rd,
                              logic mv, logic [31:0] ma, logic mw, logic [31:0] md,
                              logic [3:0] mm);
    out_t r;
    r.ir = ir; r.lr = lr; r.irv = irv; r.lrv = lrv;
    r.ird = irv ? rd : 32'h0;
    r.lrd = lrv ? rd : 32'h0;
    r.mv = mv; r.ma = ma; r.mw = mw; r.md = md; r.mm = mm;
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r.ir  = bus.ifu_req_ready;
    r.lr  = bus.lsu_req_ready;
    r.irv = bus.ifu_resp_valid;
    r.ird = bus.ifu_rdata;
    r.lrv = bus.lsu_resp_valid;
    r.lrd = bus.lsu_rdata;
    r.mv  = bus.mem_req_valid;
    r.ma  = bus.mem_addr;
    r.mw  = bus.mem_wen;
    r.md  = bus.mem_wdata;
    r.mm  = bus.mem_wmask;
    return r;
  endfunction

  task automatic drive(input in_t i);
    bus.ifu_req_valid  = i.iv;
    bus.ifu_addr       = i.ia;
    bus.lsu_req_valid  = i.lv;
    bus.lsu_addr       = i.la;
    bus.lsu_wen        = i.lw;
    bus.lsu_wdata      = i.ld;
    bus.lsu_wmask      = i.lm;
    bus.mem_req_ready  = i.mrr;
    bus.mem_resp_valid = i.mrv;
    bus.mem_rdata      = i.mrd;
  endtask

  // Memory-side fields are only meaningful while mem_req_valid is high unless full is set.
  task automatic compare(input string nm, input out_t e, input bit full);
    out_t a;
    a = sample();
    if (!full && !e.mv) begin
      a.ma = e.ma; a.mw = e.mw; a.md = e.md; a.mm = e.mm;
    end
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic cyc(input in_t i, input out_t e, input string nm);
    drive(i);
    @(negedge clk);
    compare(nm, e, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input string nm);
    drive('0);
    rst = 1'b1;
    @(negedge clk);
    compare(nm, '0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8000_0004;
  localparam logic [31:0] A2 = 32'h8000_0008;
  localparam logic [31:0] LW = 32'h8000_1000;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  initial begin
    bit    lsu_win;
    string nm;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    do_reset("reset_state");

    // Single IFU read
    add(ii(1, A0, 0, 0, 0, 0, 0, 1, 0, 0),            oo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),             oo(0, 0, 0, 0, 0, 1, A0, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h413),       oo(0, 0, 1, 0, 32'h413, 0, 0, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),             oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // LSU write with 3-cycle memory stall; IFU waits throughout
    add(ii(0, 0, 1, LW, 1, DB, 4'hF, 0, 0, 0),        oo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(ii(1, A1, 0, 0, 0, 0, 0, 0, 0, 0),            oo(0, 0, 0, 0, 0, 1, LW, 1, DB, 4'hF));
    add(ii(1, A1, 0, 0, 0, 0, 0, 0, 0, 0),            oo(0, 0, 0, 0, 0, 1, LW, 1, DB, 4'hF));
    add(ii(1, A1, 0, 0, 0, 0, 0, 0, 0, 0),            oo(0, 0, 0, 0, 0, 1, LW, 1, DB, 4'hF));
    add(ii(1, A1, 0, 0, 0, 0, 0, 1, 0, 0),            oo(0, 0, 0, 0, 0, 1, LW, 1, DB, 4'hF));
    add(ii(1, A1, 0, 0, 0, 0, 0, 0, 0, 0),            oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(ii(1, A1, 0, 0, 0, 0, 0, 0, 1, 0),            oo(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // IFU accepted next; spurious response while in REQ
    add(ii(1, A1, 0, 0, 0, 0, 0, 1, 0, 0),            oo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0),  oo(0, 0, 0, 0, 0, 1, A1, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),             oo(0, 0, 0, 0, 0, 1, A1, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678),  oo(0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0));
    // Spurious response in IDLE, then IDLE still accepts
    add(ii(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF),  oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(ii(1, A2, 0, 0, 0, 0, 0, 1, 0, 0),            oo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),             oo(0, 0, 0, 0, 0, 1, A2, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555),  oo(0, 0, 1, 0, 32'hAAAA5555, 0, 0, 0, 0, 0));
    add(ii(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),             oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) cyc(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

    // Contention: both valid every cycle for 6 transactions
    do_reset("reset_arb");
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_RR_EN
      lsu_win = ((t % 2) == 0);
`else
      lsu_win = 1'b1;
`endif
      nm = $sformatf("arb%0d", t);
      cyc(ii(1, 32'h100, 1, 32'h200, 0, 0, 0, 1, 1, 32'h1000 + 32'(t)),
          oo(!lsu_win, lsu_win, 0, 0, 0, 0, 0, 0, 0, 0), {nm, "_grant"});
      cyc(ii(1, 32'h100, 1, 32'h200, 0, 0, 0, 1, 1, 32'h1000 + 32'(t)),
          oo(0, 0, 0, 0, 0, 1, lsu_win ? 32'h200 : 32'h100, 0, 0, 0), {nm, "_req"});
      cyc(ii(1, 32'h100, 1, 32'h200, 0, 0, 0, 1, 1, 32'h1000 + 32'(t)),
          oo(0, 0, !lsu_win, lsu_win, 32'h1000 + 32'(t), 0, 0, 0, 0, 0), {nm, "_resp"});
    end

    // Reset while waiting for a response; the late response must be dropped
    do_reset("reset_pre_wait");
    cyc(ii(1, 32'h8000_0010, 0, 0, 0, 0, 0, 1, 0, 0), oo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_accept");
    cyc(ii(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), oo(0, 0, 0, 0, 0, 1, 32'h8000_0010, 0, 0, 0), "rw_req");
    cyc(ii(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_wait");
    rst = 1'b1;
    #2;
    compare("rw_in_reset", '0, 1'b1);
    @(posedge clk);
    #1;
    compare("rw_reset_held", '0, 1'b1);
    rst = 1'b0;
    cyc(ii(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD0BAD), oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_late_resp");
    cyc(ii(1, 32'h8000_0020, 0, 0, 0, 0, 0, 1, 0, 0), oo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_next_accept");
    cyc(ii(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), oo(0, 0, 0, 0, 0, 1, 32'h8000_0020, 0, 0, 0), "rw_next_req");
    cyc(ii(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A), oo(0, 0, 1, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 0), "rw_next_resp");

    // Back-to-back IFU reads, zero-wait memory: one accept every 3 cycles
    for (int t = 0; t < 4; t++) begin
      nm = $sformatf("b2b%0d", t);
      cyc(ii(1, 32'h4000 + 32'(4 * t), 0, 0, 0, 0, 0, 1, 0, 0),
          oo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), {nm, "_accept"});
      cyc(ii(1, 32'h4000 + 32'(4 * t + 4), 0, 0, 0, 0, 0, 1, 0, 0),
          oo(0, 0, 0, 0, 0, 1, 32'h4000 + 32'(4 * t), 0, 0, 0), {nm, "_req"});
      cyc(ii(1, 32'h4000 + 32'(4 * t + 4), 0, 0, 0, 0, 0, 1, 1, 32'h7700 + 32'(t)),
          oo(0, 0, 1, 0, 32'h7700 + 32'(t), 0, 0, 0, 0, 0), {nm, "_resp"});
    end
    cyc(ii(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), oo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "b2b_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and sequencer sharing the single data memory between the instruction fetch unit (IFU) and the load/store path (LSU). Accepts one request at a time over valid/ready handshakes, drives it to the memory port, waits for the memory response and routes it back to the owning requester. Sits between the IFU/EXU and the Memory block, so the core can move from combinational memory access to a handshaked, multi-cycle memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte mask width is DATA_W/8

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse)
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  write byte mask
- lsu_resp_valid  out  1  LSU read data / write ack (1-cycle pulse)
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states IDLE, REQ, WAIT; one transaction outstanding at most.
- IDLE: arbitration among asserted req_valid. The winner's req_ready is driven high combinationally; the loser's is 0. On handshake (valid && ready), latch addr/wen/wdata/wmask and owner, then go to REQ. IFU requests are latched with wen=0, wmask=0.
- REQ: mem_req_valid=1 with latched fields. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, the owner's resp_valid = 1 for that cycle and its rdata = mem_rdata, then go to IDLE. LSU writes also receive resp_valid; lsu_rdata is don't-care for writes.
- mem_resp_valid outside WAIT is ignored. The memory guarantees the response arrives at least one cycle after its request acceptance.
- Requesters hold valid and fields stable until ready; req_ready is 0 in REQ and WAIT.
- rdata outputs are mem_rdata passthrough, qualified only by resp_valid.
- Reset at any time: state=IDLE; an in-flight transaction is abandoned and its late response is ignored. Under ARB_RR_EN, last_grant is cleared to IFU.

## Timing
- Reset values: all req_ready, resp_valid and mem_req_valid are 0; mem_addr/wen/wdata/wmask are 0; ifu_rdata/lsu_rdata are undriven-as-0 when resp_valid=0.
- Minimum transaction: T0 accept (IDLE) → T1 mem_req_valid, with mem_req_ready=1 → T2 mem_resp_valid, requester resp_valid → T3 IDLE, next accept. That gives 3 cycles per access back-to-back.
- mem_req_valid is registered (state-decoded). req_ready and resp_valid are combinational from state and inputs.
- Simultaneous requests in IDLE: exactly one is granted, per Configuration.

## Configuration
- ARB_RR_EN defined: round-robin. A 1-bit last_grant register is updated on each accept. When both requesters are valid, the one not granted last wins. A lone requester always wins.
- ARB_RR_EN undefined: fixed priority, LSU over IFU. IFU starvation under continuous LSU traffic is accepted; no last_grant register is built.

## Test plan
- Single IFU read, addr 0x80000000, mem_req_ready=1, response 1 cycle later with 0x00000413 → ifu_resp_valid at T2 with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b1111, mem_req_ready held low 3 cycles → mem fields stable through the stall; lsu_resp_valid pulses once; ifu_req_ready stays 0 throughout.
- Both valid every cycle for 6 transactions → with ARB_RR_EN, grants alternate LSU/IFU starting with LSU (last_grant reset to IFU); without it, all 6 grants go to LSU.
- Spurious mem_resp_valid in IDLE and in REQ → no resp_valid to either requester; state unchanged.
- rst asserted while in WAIT, then the memory response arrives after deassert → all outputs 0 during reset; the late response is ignored; the next IFU request completes normally.
- Back-to-back IFU reads with zero-wait memory → accept every 3 cycles exactly; each resp_valid is a single-cycle pulse.
